// File: rtl/alu_pkg.sv
// Shared definitions for the registered two-operand ALU: operation encoding
// and control width.
package alu_pkg;

  localparam int unsigned CTRL_W = 2;

  typedef enum logic [CTRL_W-1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  // Signed overflow of x + y = s: operands share a sign the sum does not.
  function automatic logic add_ovf(input logic x_msb, input logic y_msb, input logic s_msb);
    return (x_msb == y_msb) && (s_msb != x_msb);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor: one shared adder, b inverted and carry-in
// raised for subtraction so a - b is formed as a + ~b + 1.
module alu_addsub
  import alu_pkg::*;
#(
  parameter int unsigned width_p = 4
) (
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  input  logic               sub_i,
  output logic [width_p-1:0] sum_o,
  output logic               ov_o
);

  logic [width_p-1:0] b_eff_s;
  logic [width_p-1:0] cin_s;

  assign b_eff_s = b_i ^ {width_p{sub_i}};
  assign cin_s   = {{(width_p-1){1'b0}}, sub_i};
  // Carry-out is intentionally dropped; the result wraps modulo 2^width_p.
  assign sum_o   = a_i + b_eff_s + cin_s;
  // With b inverted, "same sign as effective b" covers the subtract rule too.
  assign ov_o    = add_ovf(a_i[width_p-1], b_eff_s[width_p-1], sum_o[width_p-1]);

endmodule

// File: rtl/alu_reg_unit.sv
// Two-operand ALU (ADD/SUB/AND/OR) with registered result and signed
// overflow flag; one-cycle latency, synchronous active-high reset.
module alu_reg_unit
  import alu_pkg::*;
#(
  parameter int unsigned width_p = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CTRL_W-1:0]   control,
  input  logic [width_p-1:0]  a,
  input  logic [width_p-1:0]  b,
  output logic [width_p-1:0]  res,
  output logic                ov
);

  alu_op_e            op_s;
  logic               sub_s;
  logic [width_p-1:0] sum_s;
  logic               sum_ov_s;
  logic [width_p-1:0] res_d;
  logic               ov_d;
  logic [width_p-1:0] res_q;
  logic               ov_q;

  assign op_s  = alu_op_e'(control);
  assign sub_s = (op_s == ALU_SUB);

  alu_addsub #(
    .width_p (width_p)
  ) u_addsub (
    .a_i   (a),
    .b_i   (b),
    .sub_i (sub_s),
    .sum_o (sum_s),
    .ov_o  (sum_ov_s)
  );

  // Operation select; anything unrecognised behaves as ADD.
  always_comb begin
    res_d = sum_s;
    ov_d  = sum_ov_s;
    unique case (op_s)
      ALU_ADD: begin
        res_d = sum_s;
        ov_d  = sum_ov_s;
      end
      ALU_SUB: begin
        res_d = sum_s;
        ov_d  = sum_ov_s;
      end
      ALU_AND: begin
        res_d = a & b;
        ov_d  = 1'b0;
      end
      ALU_OR: begin
        res_d = a | b;
        ov_d  = 1'b0;
      end
      default: begin
        res_d = sum_s;
        ov_d  = sum_ov_s;
      end
    endcase
  end

  // Output register; reset overrides the incoming operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_q <= {width_p{1'b0}};
      ov_q  <= 1'b0;
    end else begin
      res_q <= res_d;
      ov_q  <= ov_d;
    end
  end

  assign res = res_q;
  assign ov  = ov_q;

endmodule

// File: tb/tb_alu_reg_unit.sv
// Self-checking bench for alu_reg_unit (width 4): directed vector table,
// reset and back-to-back sequences, and random stimulus against a model.
module tb_alu_reg_unit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   control;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] res;
  logic         ov;

  int errors = 0;
  int checks = 0;

  alu_reg_unit #(.width_p(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .control (control),
    .a       (a),
    .b       (b),
    .res     (res),
    .ov      (ov)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [1:0]   ctrl;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] exp_res;
    logic         exp_ov;
  } vec_t;

  vec_t vecs[12];

  // Reference: signed integer arithmetic with range test for overflow.
  function automatic void model(input logic [1:0] c, input logic [W-1:0] x,
                                input logic [W-1:0] y, output logic [W-1:0] r,
                                output logic o);
    int sx, sy, s;
    sx = $signed(x);
    sy = $signed(y);
    r = '0;
    o = 1'b0;
    case (c)
      2'b00: begin s = sx + sy; r = s[W-1:0]; o = (s > 7) || (s < -8); end
      2'b01: begin s = sx - sy; r = s[W-1:0]; o = (s > 7) || (s < -8); end
      2'b10: r = x & y;
      default: r = x | y;
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] er, input logic eo);
    checks++;
    if (res !== er || ov !== eo) begin
      errors++;
      $display("FAIL %s: got res=%b ov=%b, expected res=%b ov=%b", name, res, ov, er, eo);
    end
  endtask

  task automatic drive(input logic rst, input logic [1:0] c, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    reset = rst; control = c; a = x; b = y;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{"add_basic",   2'b00, 4'b0001, 4'b0011, 4'b0100, 1'b0};
    vecs[1]  = '{"sub_basic",   2'b01, 4'b0001, 4'b0011, 4'b1110, 1'b0};
    vecs[2]  = '{"and_basic",   2'b10, 4'b0001, 4'b0011, 4'b0001, 1'b0};
    vecs[3]  = '{"or_basic",    2'b11, 4'b0001, 4'b0011, 4'b0011, 1'b0};
    vecs[4]  = '{"add_ov_pos",  2'b00, 4'b0111, 4'b0001, 4'b1000, 1'b1};
    vecs[5]  = '{"add_ov_neg",  2'b00, 4'b1000, 4'b1000, 4'b0000, 1'b1};
    vecs[6]  = '{"sub_ov_neg",  2'b01, 4'b1000, 4'b0001, 4'b0111, 1'b1};
    vecs[7]  = '{"sub_ov_pos",  2'b01, 4'b0000, 4'b1000, 4'b1000, 1'b1};
    vecs[8]  = '{"add_wrap",    2'b00, 4'b1111, 4'b0001, 4'b0000, 1'b0};
    vecs[9]  = '{"sub_wrap",    2'b01, 4'b0000, 4'b0001, 4'b1111, 1'b0};
    vecs[10] = '{"and_no_ov",   2'b10, 4'b1000, 4'b1000, 4'b1000, 1'b0};
    vecs[11] = '{"or_no_ov",    2'b11, 4'b0111, 4'b1000, 4'b1111, 1'b0};

    // Reset held two cycles with live inputs, then release.
    drive(1'b1, 2'b00, 4'b0001, 4'b0011);
    tick();
    check("reset_cyc1", 4'b0000, 1'b0);
    tick();
    check("reset_cyc2", 4'b0000, 1'b0);
    drive(1'b0, 2'b00, 4'b0001, 4'b0011);
    tick();
    check("post_reset_add", 4'b0100, 1'b0);

    for (int i = 0; i < 12; i++) begin
      drive(1'b0, vecs[i].ctrl, vecs[i].va, vecs[i].vb);
      tick();
      check(vecs[i].name, vecs[i].exp_res, vecs[i].exp_ov);
    end

    // Outputs hold while nothing is clocked.
    drive(1'b0, 2'b00, 4'b0111, 4'b0001);
    tick();
    drive(1'b0, 2'b10, 4'b0000, 4'b0000);
    #3;
    check("hold_between_edges", 4'b1000, 1'b1);

    // Back-to-back control cycling, then reset mid-stream.
    begin
      logic [W-1:0] seq[4];
      seq[0] = 4'b0100; seq[1] = 4'b1110; seq[2] = 4'b0001; seq[3] = 4'b0011;
      for (int i = 0; i < 4; i++) begin
        drive(1'b0, 2'(i), 4'b0001, 4'b0011);
        tick();
        check($sformatf("b2b_%0d", i), seq[i], 1'b0);
      end
      drive(1'b0, 2'b00, 4'b0111, 4'b0001);
      tick();
      check("b2b_wrap_ov", 4'b1000, 1'b1);
      drive(1'b1, 2'b01, 4'b0001, 4'b0011);
      tick();
      check("mid_reset", 4'b0000, 1'b0);
      drive(1'b0, 2'b01, 4'b0001, 4'b0011);
      tick();
      check("after_mid_reset", 4'b1110, 1'b0);
    end

    // Random stimulus against the model.
    for (int i = 0; i < 300; i++) begin
      logic [1:0]   c;
      logic [W-1:0] x, y, er;
      logic         eo;
      c = 2'($urandom_range(0, 3));
      x = W'($urandom);
      y = W'($urandom);
      model(c, x, y, er, eo);
      drive(1'b0, c, x, y);
      tick();
      check($sformatf("rand_%0d_c%b_a%b_b%b", i, c, x, y), er, eo);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
